// File: rtl/fv_enc_pkg.sv
// Shared encodings for the polynomial AXI-stream transmitter.
package fv_enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/poly_regfile.sv
// Coefficient storage: one synchronous write port, one asynchronous read port, cleared by reset.
module poly_regfile #(
    parameter int N  = 16,
    parameter int QW = 8,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [QW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [QW-1:0] rdata_o
);

    logic [QW-1:0] mem_q [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Clearing on reset also keeps the streamed data at zero while reset is held.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/poly_axis_tx.sv
// Streams a stored N-coefficient polynomial over AXI-stream on each start request.
//
//   state | meaning
//   IDLE  | waiting for start; coefficient writes accepted
//   SEND  | presenting coefficient[idx]; advances on each handshake
module poly_axis_tx
    import fv_enc_pkg::*;
#(
    parameter  int N  = 16,
    parameter  int QW = 8,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          s_rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [QW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          wr_err,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [QW-1:0] m_tdata,
    output logic          m_tlast
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          done_q, done_d;
    logic          wr_err_q, wr_err_d;
    logic          rf_we;

    assign rf_we = wr_en && (state_q == IDLE);

    poly_regfile #(
        .N  (N),
        .QW (QW),
        .AW (AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (s_rst_n),
        .we_i    (rf_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (idx_q),
        .rdata_o (m_tdata)
    );

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    // In SEND, m_tvalid is 1 by construction, so m_tready alone qualifies the handshake.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        wr_err_d = wr_en && (state_q == SEND);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (m_tready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        m_tvalid = (state_q == SEND);
        m_tlast  = (state_q == SEND) && (idx_q == LAST_IDX);
        busy     = (state_q == SEND);
        done     = done_q;
        wr_err   = wr_err_q;
    end

endmodule

// File: tb/tb_poly_axis_tx.sv
// Directed and randomized checks of poly_axis_tx against a beat-queue reference model.
module tb_poly_axis_tx;

    localparam int N  = 16;
    localparam int QW = 8;
    localparam int AW = 4;

    logic          clk      = 1'b0;
    logic          s_rst_n  = 1'b0;
    logic          wr_en    = 1'b0;
    logic [AW-1:0] wr_addr  = '0;
    logic [QW-1:0] wr_data  = '0;
    logic          start    = 1'b0;
    logic          m_tready = 1'b0;
    logic          busy, done, wr_err, m_tvalid, m_tlast;
    logic [QW-1:0] m_tdata;

    int checks = 0;
    int errors = 0;

    // Reference model: stored coefficients plus the queue of beats still owed.
    logic [QW-1:0] mem_m [N];
    logic [QW-1:0] beats_q [$];
    logic          done_m = 1'b0;
    logic          err_m  = 1'b0;
    logic          restarted;

    poly_axis_tx #(.N(N), .QW(QW)) dut (
        .clk      (clk),
        .s_rst_n  (s_rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .wr_err   (wr_err),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = beats_q.size();
        chk("tvalid", 32'(m_tvalid), 32'(n > 0));
        chk("busy",   32'(busy),     32'(n > 0));
        chk("tlast",  32'(m_tlast),  32'(n == 1));
        chk("done",   32'(done),     32'(done_m));
        chk("wr_err", 32'(wr_err),   32'(err_m));
        if (n > 0) chk("tdata", 32'(m_tdata), 32'(beats_q[0]));
    endtask

    // Drive one cycle: check outputs, advance the model, cross the rising edge.
    task automatic cyc(input logic wr, input logic [AW-1:0] a, input logic [QW-1:0] d,
                       input logic st, input logic rdy);
        int n;
        n        = beats_q.size();
        wr_en    = wr;
        wr_addr  = a;
        wr_data  = d;
        start    = st;
        m_tready = rdy;
        check_outputs();
        done_m = (n == 1) && rdy;
        err_m  = wr && (n > 0);
        if (n > 0 && rdy) void'(beats_q.pop_front());
        if (wr && n == 0) mem_m[a] = d;
        if (st && n == 0) begin
            for (int i = 0; i < N; i++) beats_q.push_back(mem_m[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        s_rst_n  = 1'b0;
        wr_en    = 1'b0;
        start    = 1'b0;
        m_tready = 1'b0;
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast",  32'(m_tlast),  32'd0);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_done",   32'(done),     32'd0);
        chk("rst_wr_err", 32'(wr_err),   32'd0);
        chk("rst_tdata",  32'(m_tdata),  32'd0);
        beats_q.delete();
        for (int i = 0; i < N; i++) mem_m[i] = '0;
        done_m = 1'b0;
        err_m  = 1'b0;
        @(posedge clk);
        #1;
        s_rst_n = 1'b1;
    endtask

    initial begin
        apply_reset();

        // Ascending load, full-rate stream.
        for (int i = 0; i < N; i++) cyc(1'b1, AW'(i), QW'(i), 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < N + 2; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Alternating ready, restart in the done cycle.
        for (int i = 0; i < N; i++) cyc(1'b1, AW'(i), QW'(8'hA0 + i), 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        restarted = 1'b0;
        for (int k = 0; k < 80; k++) begin
            logic st;
            st = done_m && !restarted;
            if (st) restarted = 1'b1;
            cyc(1'b0, '0, '0, st, (k % 2) == 0);
        end

        // Write during SEND is rejected; next stream still carries the old coefficient 3.
        for (int i = 0; i < N; i++) cyc(1'b1, AW'(i), QW'($urandom), 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b1, AW'(3), 8'hFF, 1'b0, 1'b1);
        for (int k = 0; k < N + 2; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < N + 2; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Start at idx 5 is ignored.
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < N + 2; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Random data, random ready, random stray starts and writes.
        for (int i = 0; i < N; i++) cyc(1'b1, AW'(i), QW'($urandom), 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'($urandom));
        for (int k = 0; k < 120; k++) begin
            cyc(($urandom_range(0, 7) == 0), AW'($urandom), QW'($urandom),
                ($urandom_range(0, 9) == 0), 1'($urandom));
        end
        for (int k = 0; k < N + 2; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Reset at idx 7 aborts the stream and clears storage.
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        apply_reset();
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < N + 2; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Write and start in the same IDLE cycle: new value is transmitted.
        cyc(1'b1, '0, 8'h5A, 1'b1, 1'b1);
        for (int k = 0; k < N + 2; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
